jtcps1_obj_line: RTL
====================

JTCPS1_OBJ_LINE -- requirements
Module: jtcps1_obj_line

Interface
REQ-001 Parameter AW, default 9: line address width; line length is 2**AW pixels.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pxl_cen  input  1  pixel clock enable, one clk wide.
REQ-005 HB  input  1  horizontal blank, high during blanking.
REQ-006 hdump  input  AW  x position of the pixel being displayed.
REQ-007 buf_addr  input  AW  x position to write from the object draw engine.
REQ-008 buf_data  input  9  object pixel to write: [8:4] palette, [3:0] colour.
REQ-009 buf_wr  input  1  write strobe, one clk per pixel, no pxl_cen qualification.
REQ-010 obj_pxl  output  9  object pixel to the colour mixer; 9'h1FF means transparent.
REQ-011 busy  output  1  high while the init clear runs; buf_wr is ignored while it is high.

Function
REQ-012 The block SHALL hold two banks, each 2**AW x 9: a draw bank and a display bank, selected by a 1-bit register bank.
REQ-013 bank SHALL toggle on the clk where HB is 1 and HB was 0 on the previous clk; the old draw bank becomes the display bank.
REQ-014 A rising HB edge SHALL be detected once per edge, including when it coincides with pxl_cen or buf_wr.
REQ-015 A buf_wr SHALL write buf_data to the draw bank at buf_addr only if buf_data[3:0] != 4'hF; transparent writes leave memory unchanged.
REQ-016 Consecutive writes to the same address SHALL leave the last opaque value.
REQ-017 A buf_wr on the toggle clk SHALL go to the draw bank as selected before the toggle.
REQ-018 On each clk with pxl_cen=1 and HB=0, obj_pxl SHALL load display_bank[hdump], read-before-write.
REQ-019 On that same clk, display_bank[hdump] SHALL be written with 9'h1FF, so every displayed location is blank for reuse.
REQ-020 On pxl_cen=1 with HB=1, obj_pxl SHALL load 9'h1FF and no erase SHALL occur.
REQ-021 obj_pxl SHALL hold its value on clks with pxl_cen=0.
REQ-022 Read latency SHALL be one pxl_cen: the pixel for hdump=h appears at obj_pxl after the pxl_cen edge that sampled h.
REQ-023 The draw-bank write port and the display-bank erase port SHALL be independent, so a draw and an erase may occur on the same clk without loss.
REQ-024 Init FSM states SHALL be CLEAR and RUN; reset enters CLEAR with counter clr_cnt=0.
REQ-025 In CLEAR, each clk SHALL write 9'h1FF to address clr_cnt in both banks and increment clr_cnt.
REQ-026 When clr_cnt reaches all-ones and is written, the FSM SHALL go to RUN; CLEAR lasts exactly 2**AW clks.
REQ-027 In CLEAR, busy SHALL be 1, obj_pxl SHALL be 9'h1FF, and buf_wr and erase SHALL be ignored.
REQ-028 HB edges SHALL still toggle bank in CLEAR.
REQ-029 In RUN, busy SHALL be 0.
REQ-030 hdump and buf_addr SHALL be used modulo 2**AW; no out-of-range behaviour exists.

Reset
REQ-031 Reset SHALL set obj_pxl=9'h1FF, busy=1, bank=0, clr_cnt=0, FSM=CLEAR, and the HB edge register to 1.
REQ-032 Reset asserted mid-CLEAR or mid-line SHALL restart CLEAR from address 0.
REQ-033 Memory contents written before reset are undefined until CLEAR completes.

Verification
REQ-034 Release reset -> busy stays 1 for exactly 512 clks (AW=9) and obj_pxl=9'h1FF throughout; then busy=0.
REQ-035 Write addr 10 data 9'h0A3 and addr 11 data 9'h0AF during line N; raise HB, then display line N+1 -> obj_pxl=9'h0A3 at hdump=10 and 9'h1FF at hdump=11.
REQ-036 After REQ-035, redisplay the same bank two lines later with no new writes -> hdump=10 reads 9'h1FF (erased).
REQ-037 Write addr 5 with 9'h012 then 9'h034 in one line -> next line shows 9'h034 at hdump=5.
REQ-038 Assert buf_wr on the same clk as the HB rising edge, with pxl_cen=1 -> data lands in the pre-toggle draw bank and appears on the following line; bank toggles exactly once.
REQ-039 Assert rst mid-line with opaque data stored -> CLEAR restarts at 0 and all addresses read 9'h1FF after busy falls.

Source files
------------

// File: rtl/jtcps1_obj_line.sv
// Double-buffered object line buffer: one bank takes draw-engine pixels while the
// other is scanned out and erased behind the beam. Banks swap on each rising HB.
`timescale 1ns/1ps
module jtcps1_obj_line #(
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          HB,
  input  logic [AW-1:0] hdump,
  input  logic [AW-1:0] buf_addr,
  input  logic [8:0]    buf_data,
  input  logic          buf_wr,
  output logic [8:0]    obj_pxl,
  output logic          busy
);

  localparam int unsigned Len   = 2**AW;
  localparam logic [8:0]  Blank = 9'h1FF;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e        r_state, w_state_next;
  logic [AW-1:0] r_clr_cnt;
  logic          r_bank;
  logic          r_hb_last;
  logic [8:0]    r_obj_pxl;

  logic [8:0]    r_mem0 [Len];
  logic [8:0]    r_mem1 [Len];

  logic          w_hb_rise;
  logic          w_run;
  logic          w_draw_we;
  logic          w_erase;
  logic [8:0]    w_disp_rd;
  logic          w_we0, w_we1;
  logic [AW-1:0] w_wa0, w_wa1;
  logic [8:0]    w_wd0, w_wd1;

  assign w_hb_rise = HB & ~r_hb_last;
  assign w_run     = (r_state == StRun);
  assign w_draw_we = w_run & buf_wr & (buf_data[3:0] != 4'hF);
  assign w_erase   = w_run & pxl_cen & ~HB;
  // r_bank selects the draw bank; the display bank is the other one
  assign w_disp_rd = r_bank ? r_mem0[hdump] : r_mem1[hdump];

  always_comb begin
    w_state_next = r_state;
    if (r_state == StClear && r_clr_cnt == '1) w_state_next = StRun;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StClear;
      r_clr_cnt <= '0;
      r_bank    <= 1'b0;
      r_hb_last <= 1'b1;
      r_obj_pxl <= Blank;
    end else begin
      r_state   <= w_state_next;
      r_hb_last <= HB;
      if (r_state == StClear) r_clr_cnt <= r_clr_cnt + 1'b1;
      if (w_hb_rise) r_bank <= ~r_bank;
      if (!w_run) begin
        r_obj_pxl <= Blank;
      end else if (pxl_cen) begin
        r_obj_pxl <= HB ? Blank : w_disp_rd;
      end
    end
  end

  // Each physical bank has a single write port: clear, draw or erase, never two at once
  always_comb begin
    w_we0 = 1'b0;
    w_wa0 = '0;
    w_wd0 = Blank;
    w_we1 = 1'b0;
    w_wa1 = '0;
    w_wd1 = Blank;
    if (!w_run) begin
      w_we0 = 1'b1;
      w_wa0 = r_clr_cnt;
      w_we1 = 1'b1;
      w_wa1 = r_clr_cnt;
    end else if (r_bank == 1'b0) begin
      w_we0 = w_draw_we;
      w_wa0 = buf_addr;
      w_wd0 = buf_data;
      w_we1 = w_erase;
      w_wa1 = hdump;
    end else begin
      w_we1 = w_draw_we;
      w_wa1 = buf_addr;
      w_wd1 = buf_data;
      w_we0 = w_erase;
      w_wa0 = hdump;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we0) r_mem0[w_wa0] <= w_wd0;
  end

  always_ff @(posedge clk) begin
    if (w_we1) r_mem1[w_wa1] <= w_wd1;
  end

  assign obj_pxl = r_obj_pxl;
  assign busy    = ~w_run;

endmodule
